lsu_tl_master: RTL and testbench

Single-outstanding TileLink-UL/UH initiator that turns load, store and AMO requests from the CPU load/store unit into one A-channel beat and one D-channel response. It issues Get, PutFull/PutPartial, ArithmeticData or LogicalData on a `tilelink.master` port. It returns the D-channel word right-aligned and sign- or zero-extended to the core. It sits between the LSU and the crossbar, with the RAM and MMIO slaves behind it.

---
 rtl/lsu_tl_master_if.sv | 43 ++++
 rtl/lsu_tl_master.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_lsu_tl_master.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_tl_master_if.sv
// rtl/lsu_tl_master_if.sv - TileLink-UL/UH A/D channel bundle between an initiator and a slave
//
// A channel (master -> slave): a_valid, a_opcode, a_param, a_size, a_source,
//   a_address, a_mask, a_data, a_corrupt; a_ready flows back from the slave.
// D channel (slave -> master): d_valid, d_opcode, d_param, d_size, d_source,
//   d_sink, d_denied, d_data, d_corrupt; d_ready flows back from the master.
interface lsu_tl_master_if;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_opcode;
   logic [2:0]  a_param;
   logic [2:0]  a_size;
   logic [7:0]  a_source;
   logic [63:0] a_address;
   logic [7:0]  a_mask;
   logic [63:0] a_data;
   logic        a_corrupt;

   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_opcode;
   logic [1:0]  d_param;
   logic [2:0]  d_size;
   logic [7:0]  d_source;
   logic        d_sink;
   logic        d_denied;
   logic [63:0] d_data;
   logic        d_corrupt;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      input  a_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
      output d_ready
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      output a_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
      input  d_ready
   );
endinterface

// File: rtl/lsu_tl_master.sv
// rtl/lsu_tl_master.sv - single-outstanding TileLink initiator for LSU load/store/AMO requests
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_req_*         : request from the LSU (valid/op/addr/size/signed/wdata), o_req_ready back
//   o_rsp_*         : response to the LSU (valid/data/err), i_rsp_ready back
//   bus             : TileLink master port (A channel + d_ready driven, D channel sampled)
//
// Request op encoding (i_req_op):
//   0 LOAD, 1 STORE, 2 AMO_ADD, 3 AMO_MIN, 4 AMO_MAX, 5 AMO_MINU, 6 AMO_MAXU,
//   7 AMO_SWAP, 8 AMO_XOR, 9 AMO_OR, 10 AMO_AND; other codes are issued as a Get.
module lsu_tl_master #(
   parameter int unsigned SOURCE_ID = 0,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [3:0]  i_req_op,
   input  logic [63:0] i_req_addr,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_signed,
   input  logic [63:0] i_req_wdata,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [63:0] o_rsp_data,
   output logic        o_rsp_err,
   lsu_tl_master_if.master bus
);

   localparam logic [3:0] OP_LOAD     = 4'd0;
   localparam logic [3:0] OP_STORE    = 4'd1;
   localparam logic [3:0] OP_AMO_ADD  = 4'd2;
   localparam logic [3:0] OP_AMO_MIN  = 4'd3;
   localparam logic [3:0] OP_AMO_MAX  = 4'd4;
   localparam logic [3:0] OP_AMO_MINU = 4'd5;
   localparam logic [3:0] OP_AMO_MAXU = 4'd6;
   localparam logic [3:0] OP_AMO_SWAP = 4'd7;
   localparam logic [3:0] OP_AMO_XOR  = 4'd8;
   localparam logic [3:0] OP_AMO_OR   = 4'd9;
   localparam logic [3:0] OP_AMO_AND  = 4'd10;

   localparam logic [2:0] TL_PUT_F      = 3'd0;
   localparam logic [2:0] TL_PUT_P      = 3'd1;
   localparam logic [2:0] TL_ARITH_DATA = 3'd2;
   localparam logic [2:0] TL_LOGIC_DATA = 3'd3;
   localparam logic [2:0] TL_GET        = 3'd4;

   localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

   localparam logic [2:0] TL_PARAM_MIN  = 3'd0;
   localparam logic [2:0] TL_PARAM_MAX  = 3'd1;
   localparam logic [2:0] TL_PARAM_MINU = 3'd2;
   localparam logic [2:0] TL_PARAM_MAXU = 3'd3;
   localparam logic [2:0] TL_PARAM_ADD  = 3'd4;
   localparam logic [2:0] TL_PARAM_XOR  = 3'd0;
   localparam logic [2:0] TL_PARAM_OR   = 3'd1;
   localparam logic [2:0] TL_PARAM_AND  = 3'd2;
   localparam logic [2:0] TL_PARAM_SWAP = 3'd3;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;

   state_t      r_state;
   state_t      w_state_nx;

   // Request context kept for response extraction.
   logic        r_is_put;
   logic        r_is_amo;
   logic        r_signed;
   logic [1:0]  r_size;
   logic [2:0]  r_addr_lo;

   // Registered A-channel fields.
   logic [2:0]  r_a_opcode;
   logic [2:0]  r_a_param;
   logic [2:0]  r_a_size;
   logic [7:0]  r_a_source;
   logic [63:0] r_a_address;
   logic [7:0]  r_a_mask;
   logic [63:0] r_a_data;

   logic [63:0] r_rsp_data;
   logic        r_rsp_err;
   logic [31:0] r_cnt;

   logic [2:0]  w_a_opcode;
   logic [2:0]  w_a_param;
   logic [7:0]  w_a_mask;
   logic [2:0]  w_align_mask;
   logic        w_misaligned;
   logic        w_d_hit;
   logic        w_timeout;
   logic [63:0] w_d_shift;
   logic        w_sext;
   logic [63:0] w_d_ext;
   logic [63:0] w_rsp_data;
   logic        w_opc_ok;
   logic        w_req_ready;
   logic        w_a_valid;
   logic        w_d_ready;
   logic        w_rsp_valid;
   logic        w_unused_d;

   // D-channel fields the initiator does not act on; d_denied is deliberately ignored.
   assign w_unused_d = ^{bus.d_param, bus.d_size, bus.d_sink, bus.d_denied, bus.d_corrupt};

   // Opcode/param mapping for the incoming request.
   always_comb begin
      w_a_opcode = TL_GET;
      w_a_param  = 3'd0;
      case (i_req_op)
         OP_LOAD:     w_a_opcode = TL_GET;
         OP_STORE:    w_a_opcode = (i_req_size == 2'd3) ? TL_PUT_F : TL_PUT_P;
         OP_AMO_ADD:  begin w_a_opcode = TL_ARITH_DATA; w_a_param = TL_PARAM_ADD;  end
         OP_AMO_MIN:  begin w_a_opcode = TL_ARITH_DATA; w_a_param = TL_PARAM_MIN;  end
         OP_AMO_MAX:  begin w_a_opcode = TL_ARITH_DATA; w_a_param = TL_PARAM_MAX;  end
         OP_AMO_MINU: begin w_a_opcode = TL_ARITH_DATA; w_a_param = TL_PARAM_MINU; end
         OP_AMO_MAXU: begin w_a_opcode = TL_ARITH_DATA; w_a_param = TL_PARAM_MAXU; end
         OP_AMO_SWAP: begin w_a_opcode = TL_LOGIC_DATA; w_a_param = TL_PARAM_SWAP; end
         OP_AMO_XOR:  begin w_a_opcode = TL_LOGIC_DATA; w_a_param = TL_PARAM_XOR;  end
         OP_AMO_OR:   begin w_a_opcode = TL_LOGIC_DATA; w_a_param = TL_PARAM_OR;   end
         OP_AMO_AND:  begin w_a_opcode = TL_LOGIC_DATA; w_a_param = TL_PARAM_AND;  end
         default:     ;
      endcase
   end

   // Right-aligned byte mask and the low-address bits that must be zero for alignment.
   always_comb begin
      w_a_mask     = 8'hFF;
      w_align_mask = 3'b111;
      case (i_req_size)
         2'd0:    begin w_a_mask = 8'h01; w_align_mask = 3'b000; end
         2'd1:    begin w_a_mask = 8'h03; w_align_mask = 3'b001; end
         2'd2:    begin w_a_mask = 8'h0F; w_align_mask = 3'b011; end
         default: begin w_a_mask = 8'hFF; w_align_mask = 3'b111; end
      endcase
   end

   assign w_misaligned = (i_req_addr[2:0] & w_align_mask) != 3'b000;
   assign w_d_hit      = bus.d_valid && (bus.d_source == 8'(SOURCE_ID));
   assign w_timeout    = (32'(TIMEOUT) != 32'd0) && (r_cnt == 32'(TIMEOUT) - 32'd1);

   // Pull the addressed lane down to bit 0, then truncate and extend. AMOs always
   // sign-extend so that .W results match RV64 register semantics.
   assign w_d_shift = bus.d_data >> {r_addr_lo, 3'b000};
   assign w_sext    = r_is_amo | r_signed;

   always_comb begin
      w_d_ext = w_d_shift;
      case (r_size)
         2'd0:    w_d_ext = {{56{w_sext & w_d_shift[7]}},  w_d_shift[7:0]};
         2'd1:    w_d_ext = {{48{w_sext & w_d_shift[15]}}, w_d_shift[15:0]};
         2'd2:    w_d_ext = {{32{w_sext & w_d_shift[31]}}, w_d_shift[31:0]};
         default: w_d_ext = w_d_shift;
      endcase
   end

   assign w_rsp_data = r_is_put ? 64'd0 : w_d_ext;
   assign w_opc_ok   = bus.d_opcode == (r_is_put ? TL_ACCESS_ACK : TL_ACCESS_ACK_DATA);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next state and state-decoded handshake outputs.
   always_comb begin
      w_state_nx  = r_state;
      w_req_ready = 1'b0;
      w_a_valid   = 1'b0;
      w_d_ready   = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req_ready = 1'b1;
            if (i_req_valid) begin
               w_state_nx = w_misaligned ? S_RSP : S_REQ;
            end
         end
         S_REQ: begin
            w_a_valid = 1'b1;
            if (bus.a_ready) begin
               w_state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            w_d_ready = 1'b1;
            if (w_d_hit || w_timeout) begin
               w_state_nx = S_RSP;
            end
         end
         S_RSP: begin
            w_rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_put    <= 1'b0;
         r_is_amo    <= 1'b0;
         r_signed    <= 1'b0;
         r_size      <= 2'd0;
         r_addr_lo   <= 3'd0;
         r_a_opcode  <= 3'd0;
         r_a_param   <= 3'd0;
         r_a_size    <= 3'd0;
         r_a_source  <= 8'd0;
         r_a_address <= 64'd0;
         r_a_mask    <= 8'd0;
         r_a_data    <= 64'd0;
         r_rsp_data  <= 64'd0;
         r_rsp_err   <= 1'b0;
         r_cnt       <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_is_put    <= i_req_op == OP_STORE;
                  r_is_amo    <= (i_req_op >= OP_AMO_ADD) && (i_req_op <= OP_AMO_AND);
                  r_signed    <= i_req_signed;
                  r_size      <= i_req_size;
                  r_addr_lo   <= i_req_addr[2:0];
                  r_a_opcode  <= w_a_opcode;
                  r_a_param   <= w_a_param;
                  r_a_size    <= {1'b0, i_req_size};
                  r_a_source  <= 8'(SOURCE_ID);
                  r_a_address <= i_req_addr;
                  r_a_mask    <= w_a_mask;
                  r_a_data    <= i_req_wdata;
                  if (w_misaligned) begin
                     r_rsp_data <= 64'd0;
                     r_rsp_err  <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               r_cnt <= 32'd0;
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 32'd1;
               if (w_d_hit) begin
                  // Opcode mismatch still returns the data, flagged as an error.
                  r_rsp_data <= w_rsp_data;
                  r_rsp_err  <= !w_opc_ok;
               end else if (w_timeout) begin
                  r_rsp_data <= 64'd0;
                  r_rsp_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_req_ready   = w_req_ready;
   assign o_rsp_valid   = w_rsp_valid;
   assign o_rsp_data    = r_rsp_data;
   assign o_rsp_err     = r_rsp_err;

   assign bus.a_valid   = w_a_valid;
   assign bus.a_opcode  = r_a_opcode;
   assign bus.a_param   = r_a_param;
   assign bus.a_size    = r_a_size;
   assign bus.a_source  = r_a_source;
   assign bus.a_address = r_a_address;
   assign bus.a_mask    = r_a_mask;
   assign bus.a_data    = r_a_data;
   assign bus.a_corrupt = 1'b0;
   assign bus.d_ready   = w_d_ready;

endmodule

// File: tb/tb_lsu_tl_master.sv
// tb/tb_lsu_tl_master.sv - directed self-checking bench for lsu_tl_master
module tb_lsu_tl_master;
   localparam int unsigned SRC = 3;

   localparam logic [3:0] OP_LOAD = 4'd0, OP_STORE = 4'd1, OP_AMO_ADD = 4'd2, OP_AMO_XOR = 4'd8;
   localparam logic [2:0] PUT_F = 3'd0, PUT_P = 3'd1, ARITH = 3'd2, LOGIC = 3'd3, GET = 3'd4;
   localparam logic [2:0] ACK = 3'd0, ACK_DATA = 3'd1;
   localparam logic [2:0] P_ADD = 3'd4, P_XOR = 3'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_signed;
   logic [3:0]  req_op;
   logic [63:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lsu_tl_master_if tl();

   lsu_tl_master #(.SOURCE_ID(SRC), .TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_op     (req_op),
      .i_req_addr   (req_addr),
      .i_req_size   (req_size),
      .i_req_signed (req_signed),
      .i_req_wdata  (req_wdata),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_data   (rsp_data),
      .o_rsp_err    (rsp_err),
      .bus          (tl)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request and let it be accepted; returns at the falling edge of cycle 1.
   task automatic issue(input logic [3:0] op, input logic [63:0] addr, input logic [1:0] sz,
                        input logic sg, input logic [63:0] wd);
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1; req_op = op; req_addr = addr; req_size = sz; req_signed = sg; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
   endtask

   // Check the A beat in cycle 1; returns at the falling edge of cycle 2.
   task automatic check_a(input string tag, input logic [2:0] aop, input logic [2:0] prm,
                          input logic [63:0] addr, input logic [1:0] sz, input logic [7:0] mask,
                          input logic [63:0] wd);
      chk({tag, ".a_valid"}, tl.a_valid, 1);
      chk({tag, ".a_fields"}, {tl.a_opcode, tl.a_param, tl.a_size, tl.a_mask, tl.a_source, tl.a_corrupt},
          {aop, prm, 1'b0, sz, mask, 8'(SRC), 1'b0});
      chk({tag, ".a_address"}, tl.a_address, addr);
      chk({tag, ".a_data"}, tl.a_data, wd);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic respond(input string tag, input logic [2:0] dop, input logic [7:0] src,
                          input logic [63:0] dd);
      chk({tag, ".d_ready"}, tl.d_ready, 1);
      tl.d_valid = 1; tl.d_opcode = dop; tl.d_source = src; tl.d_data = dd;
      @(posedge clk);
      @(negedge clk);
      tl.d_valid = 0;
   endtask

   task automatic check_rsp(input string tag, input logic [63:0] exp_data, input logic exp_err);
      chk({tag, ".rsp_valid"}, rsp_valid, 1);
      chk({tag, ".rsp_data"}, rsp_data, exp_data);
      chk({tag, ".rsp_err"}, rsp_err, exp_err);
      rsp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 0;
      chk({tag, ".ready_back"}, {rsp_valid, req_ready}, 2'b01);
   endtask

   task automatic txn(input string tag, input logic [3:0] op, input logic [63:0] addr,
                      input logic [1:0] sz, input logic sg, input logic [63:0] wd,
                      input logic [2:0] aop, input logic [2:0] prm, input logic [7:0] mask,
                      input logic [2:0] dop, input logic [63:0] dd,
                      input logic [63:0] exp_data, input logic exp_err);
      issue(op, addr, sz, sg, wd);
      check_a(tag, aop, prm, addr, sz, mask, wd);
      respond(tag, dop, 8'(SRC), dd);
      check_rsp(tag, exp_data, exp_err);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, ".handshake"}, {req_ready, rsp_valid, rsp_err, tl.a_valid, tl.d_ready}, 5'b10000);
      chk({tag, ".rsp_data"}, rsp_data, 0);
      chk({tag, ".a_fields"}, {tl.a_opcode, tl.a_param, tl.a_size, tl.a_mask, tl.a_source, tl.a_corrupt}, 0);
      chk({tag, ".a_address"}, tl.a_address, 0);
      chk({tag, ".a_data"}, tl.a_data, 0);
   endtask

   initial begin
      int waits;
      rst = 1; req_valid = 0; req_op = 0; req_addr = 0; req_size = 0; req_signed = 0;
      req_wdata = 0; rsp_ready = 0;
      tl.a_ready = 1; tl.d_valid = 0; tl.d_opcode = 0; tl.d_param = 0; tl.d_size = 0;
      tl.d_source = 0; tl.d_sink = 0; tl.d_denied = 0; tl.d_data = 0; tl.d_corrupt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      check_reset_state("reset");

      // Store then load a full doubleword; txn also checks rsp_valid in cycle 3.
      txn("st8", OP_STORE, 64'h100, 2'd3, 0, 64'h1122334455667788, PUT_F, 3'd0, 8'hFF,
          ACK, 64'hDEAD, 64'd0, 0);
      txn("ld8", OP_LOAD, 64'h100, 2'd3, 0, 64'd0, GET, 3'd0, 8'hFF,
          ACK_DATA, 64'h1122334455667788, 64'h1122334455667788, 0);

      // Byte loads from the top lane.
      txn("lb_s", OP_LOAD, 64'h107, 2'd0, 1, 64'd0, GET, 3'd0, 8'h01,
          ACK_DATA, 64'h1122334455667788, 64'h11, 0);
      txn("lb_u", OP_LOAD, 64'h107, 2'd0, 0, 64'd0, GET, 3'd0, 8'h01,
          ACK_DATA, 64'h1122334455667788, 64'h11, 0);
      txn("sb", OP_STORE, 64'h106, 2'd0, 0, 64'h80, PUT_P, 3'd0, 8'h01,
          ACK, 64'd0, 64'd0, 0);
      txn("lb_neg", OP_LOAD, 64'h106, 2'd0, 1, 64'd0, GET, 3'd0, 8'h01,
          ACK_DATA, 64'h1180334455667788, 64'hFFFFFFFFFFFFFF80, 0);

      // AMOs: positive and negative old values, both sign-extended.
      txn("amoadd_w", OP_AMO_ADD, 64'h104, 2'd2, 0, 64'd1, ARITH, P_ADD, 8'h0F,
          ACK_DATA, 64'h7FFFFFFF55667788, 64'h000000007FFFFFFF, 0);
      txn("lw_after", OP_LOAD, 64'h104, 2'd2, 1, 64'd0, GET, 3'd0, 8'h0F,
          ACK_DATA, 64'h8000000055667788, 64'hFFFFFFFF80000000, 0);
      txn("amoxor_h", OP_AMO_XOR, 64'h100, 2'd1, 0, 64'h00FF, LOGIC, P_XOR, 8'h03,
          ACK_DATA, 64'h800000005566F00F, 64'hFFFFFFFFFFFFF00F, 0);

      // Wrong D opcode: error flagged, data still returned.
      txn("opc_err", OP_LOAD, 64'h100, 2'd3, 0, 64'd0, GET, 3'd0, 8'hFF,
          ACK, 64'hAA, 64'hAA, 1);

      // Misaligned word: error one cycle after accept, no A beat.
      issue(OP_LOAD, 64'h102, 2'd2, 0, 64'd0);
      chk("misalign.a_valid", tl.a_valid, 0);
      check_rsp("misalign", 64'd0, 1);

      // Beats from a foreign source are dropped while waiting.
      issue(OP_LOAD, 64'h108, 2'd3, 0, 64'd0);
      check_a("src", GET, 3'd0, 64'h108, 2'd3, 8'hFF, 64'd0);
      respond("src_foreign", ACK_DATA, 8'd5, 64'h5555);
      chk("src_foreign.rsp_valid", rsp_valid, 0);
      respond("src_own", ACK_DATA, 8'(SRC), 64'h0102030405060708);
      check_rsp("src", 64'h0102030405060708, 0);

      // Timeout after exactly 16 wait cycles; a late beat is refused.
      issue(OP_LOAD, 64'h200, 2'd3, 0, 64'd0);
      check_a("tmo", GET, 3'd0, 64'h200, 2'd3, 8'hFF, 64'd0);
      waits = 0;
      while (!rsp_valid && waits < 100) begin
         if (tl.d_ready) waits++;
         @(posedge clk);
         @(negedge clk);
      end
      chk("tmo.wait_cycles", 64'(waits), 16);
      chk("tmo.d_ready_off", tl.d_ready, 0);
      tl.d_valid = 1; tl.d_opcode = ACK_DATA; tl.d_source = 8'(SRC); tl.d_data = 64'h5A5A;
      @(posedge clk);
      @(negedge clk);
      tl.d_valid = 0;
      check_rsp("tmo", 64'd0, 1);

      // Response stall: data held stable for 5 cycles with rsp_ready low.
      issue(OP_LOAD, 64'h100, 2'd3, 0, 64'd0);
      check_a("stall", GET, 3'd0, 64'h100, 2'd3, 8'hFF, 64'd0);
      respond("stall", ACK_DATA, 8'(SRC), 64'h0123456789ABCDEF);
      for (int i = 0; i < 5; i++) begin
         chk("stall.hold", {rsp_valid, rsp_err, rsp_data}, {2'b10, 64'h0123456789ABCDEF});
         @(posedge clk);
         @(negedge clk);
      end
      check_rsp("stall", 64'h0123456789ABCDEF, 0);

      // Asynchronous reset while waiting for D.
      issue(OP_LOAD, 64'h100, 2'd3, 0, 64'd0);
      check_a("rstw", GET, 3'd0, 64'h100, 2'd3, 8'hFF, 64'd0);
      chk("rstw.in_wait", tl.d_ready, 1);
      #2 rst = 1;
      #1 check_reset_state("rst_mid");
      @(negedge clk);
      rst = 0;
      // The lost slave response arriving now must be ignored in S_IDLE.
      tl.d_valid = 1; tl.d_opcode = ACK_DATA; tl.d_source = 8'(SRC); tl.d_data = 64'h77;
      @(posedge clk);
      @(negedge clk);
      tl.d_valid = 0;
      chk("rst_mid.late_d", {rsp_valid, req_ready}, 2'b01);
      txn("after_rst", OP_LOAD, 64'h100, 2'd3, 0, 64'd0, GET, 3'd0, 8'hFF,
          ACK_DATA, 64'hCAFEF00D12345678, 64'hCAFEF00D12345678, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
